// File: rtl/product_accumulator_if.sv
// Synchronous RAM read bus between product_accumulator (master) and the
// product RAM (slave).
interface product_accumulator_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
);
  logic [AW-1:0] mem_adr;
  logic          mem_rd;
  logic [DW-1:0] mem_data;

  modport master (output mem_adr, output mem_rd, input mem_data);
  modport slave  (input mem_adr, input mem_rd, output mem_data);
endinterface

// File: rtl/product_accumulator.sv
// Sums a run of consecutive product-RAM entries and, when PRODUCT_ACC_MAX_EN
// is defined, tracks the largest entry and its address.
module product_accumulator #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3,
  parameter int unsigned SW = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW-1:0]        first_adr,
  input  logic [AW:0]          count,
  product_accumulator_if.master mem,
  output logic                 busy,
  output logic                 done,
  output logic [SW-1:0]        sum,
  output logic [DW-1:0]        max_val,
  output logic [AW-1:0]        max_adr
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  state_t      state;
  logic [AW:0] remaining;
  logic [AW:0] count_clamped;
  logic        rd_q;

  always_comb begin
    count_clamped = count;
    if (count > DEPTH) count_clamped = DEPTH;
  end

  // rd_q marks the cycle in which mem_data answers last cycle's read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      mem.mem_adr <= '0;
      mem.mem_rd  <= 1'b0;
      rd_q        <= 1'b0;
      remaining   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sum         <= '0;
    end else begin
      rd_q <= mem.mem_rd;
      done <= 1'b0;
      if (rd_q) sum <= sum + {{(SW-DW){1'b0}}, mem.mem_data};
      case (state)
        IDLE: begin
          if (start) begin
            mem.mem_adr <= first_adr;
            remaining   <= count_clamped;
            sum         <= '0;
            if (count_clamped == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= READ;
              mem.mem_rd <= 1'b1;
              busy       <= 1'b1;
            end
          end
        end
        READ: begin
          mem.mem_adr <= mem.mem_adr + 1'b1;
          remaining   <= remaining - 1'b1;
          if (remaining == {{AW{1'b0}}, 1'b1}) begin
            state      <= DRAIN;
            mem.mem_rd <= 1'b0;
          end
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PRODUCT_ACC_MAX_EN
  logic [AW-1:0] adr_q;

  // Strict compare keeps the earliest-read address on ties
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adr_q   <= '0;
      max_val <= '0;
      max_adr <= '0;
    end else begin
      adr_q <= mem.mem_adr;
      if (state == IDLE && start) begin
        max_val <= '0;
        max_adr <= first_adr;
      end else if (rd_q && (mem.mem_data > max_val)) begin
        max_val <= mem.mem_data;
        max_adr <= adr_q;
      end
    end
  end
`else
  assign max_val = '0;
  assign max_adr = '0;
`endif

endmodule
